seq_pattern_detector: RTL

//   Parametrised serial pattern detector; successor to the 1-bit Mealy detector.

---
 rtl/seq_pattern_detector.sv | 91 +++++++++
 1 files changed

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - parametrised serial pattern detector with Mealy match flag
//
// Purpose:
//   Shifts in one serial bit per enabled clock. It raises z in the same cycle
//   that the last bit of PATTERN arrives. Matching can overlap or be
//   non-overlapping. A saturating counter records the number of matches.
//
// Ports:
//   ck         in   1      clock, rising edge
//   reset      in   1      synchronous reset, active-low
//   en         in   1      x is sampled only when en=1
//   clr        in   1      synchronous clear of history and counter, active-high
//   x          in   1      serial data bit
//   z          out  1      Mealy match flag (combinational)
//   match_cnt  out  CNT_W  matches since reset/clr, saturating
//   fill       out  W_F    number of valid history bits, 0..PATTERN_W-1

module seq_pattern_detector #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8,
  localparam int                  W_F       = $clog2(PATTERN_W)
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             x,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic [W_F-1:0]   fill
);

  localparam logic [W_F-1:0]   FILL_MAX = W_F'(PATTERN_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [PATTERN_W-2:0] hist_q, hist_d;
  logic [W_F-1:0]       fill_q, fill_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PATTERN_W-1:0] cand;
  logic                 hist_full;
  logic                 z_int;

  // The candidate word ends with the bit that is arriving now. This lets a
  // match be flagged in the same cycle that bit is presented.
  assign cand      = {hist_q, x};
  assign hist_full = (fill_q == FILL_MAX);
  assign z_int     = reset & ~clr & en & hist_full & (cand == PATTERN);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (!reset || clr) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (en) begin
      if (z_int && !OVERLAP) begin
        // Non-overlapping mode: flush the history so that the next match
        // needs a complete set of new bits.
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = cand[PATTERN_W-2:0];
        fill_d = hist_full ? fill_q : fill_q + 1'b1;
      end
      if (z_int && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign z         = z_int;
  assign match_cnt = cnt_q;
  assign fill      = fill_q;

endmodule
